// File: rtl/demux3x1_sequencial_if.sv
// ---------------------------------------------------------------------------
// demux3x1_sequencial_if
// Bundles the sample stream, lane-select controls and the tap-triple
// output of the 1-to-3 distributor.
//   master : sample source / triple consumer (drives din, din_valid, manual,
//            c0, c1, flush, out_ready; observes din_ready, dout_*, fill)
//   slave  : the distributor itself (the opposite directions)
// ---------------------------------------------------------------------------
interface demux3x1_sequencial_if #(
  parameter int DATA_WIDTH = 10
);
  logic [DATA_WIDTH-1:0] din;
  logic                  din_valid;
  logic                  din_ready;
  logic                  manual;
  logic                  c0;
  logic                  c1;
  logic                  flush;
  logic [DATA_WIDTH-1:0] dout_0;
  logic [DATA_WIDTH-1:0] dout_1;
  logic [DATA_WIDTH-1:0] dout_2;
  logic                  dout_valid;
  logic                  out_ready;
  logic [1:0]            fill;

  modport master (
    output din, din_valid, manual, c0, c1, flush, out_ready,
    input  din_ready, dout_0, dout_1, dout_2, dout_valid, fill
  );

  modport slave (
    input  din, din_valid, manual, c0, c1, flush, out_ready,
    output din_ready, dout_0, dout_1, dout_2, dout_valid, fill
  );
endinterface

// File: rtl/demux3x1_sequencial.sv
// ---------------------------------------------------------------------------
// demux3x1_sequencial
// Registered 1-to-3 distributor: collects samples into three lane registers
// and offers them as one tap triple once every lane holds fresh data.
// Lanes fill either in order (manual=0) or at the lane addressed by {c1,c0}
// (manual=1, c1 has priority, same encoding as the 3:1 tap-select mux).
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset
//   bus  - slave side of demux3x1_sequencial_if:
//          din/din_valid/din_ready : sample input handshake
//          manual, c0, c1          : fill mode and manual lane select
//          flush                   : discard the current (partial) triple
//          dout_0..2/dout_valid/out_ready : tap triple output handshake
//          fill                    : number of lanes currently full
// ---------------------------------------------------------------------------
module demux3x1_sequencial #(
  parameter int DATA_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  demux3x1_sequencial_if.slave  bus
);

  // The lane-full mask is the FSM state: 000 EMPTY, then ONE/TWO, 111 FULL.
  logic [2:0]                  mask_reg;
  logic [2:0]                  mask_next;
  logic [2:0]                  base_mask;
  logic [2:0]                  target_onehot;
  logic [2:0]                  lane_we;
  logic [2:0][DATA_WIDTH-1:0]  lane_data;

  logic full;
  logic ready_int;
  logic accept_hit;
  logic release_hit;

  assign full        = &mask_reg;
  assign ready_int   = ~full | bus.out_ready;
  assign accept_hit  = bus.din_valid & ready_int;
  assign release_hit = full & bus.out_ready;

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mask_reg <= 3'b000;
    end else begin
      mask_reg <= mask_next;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    // A release empties the triple before the incoming sample is placed, so
    // in automatic mode a simultaneous accept always lands in lane 0.
    base_mask = release_hit ? 3'b000 : mask_reg;

    target_onehot = 3'b000;
    if (bus.manual) begin
      if (bus.c1) begin
        target_onehot = 3'b100;
      end else if (bus.c0) begin
        target_onehot = 3'b010;
      end else begin
        target_onehot = 3'b001;
      end
    end else begin
      // Lowest empty lane; lanes already filled manually are skipped.
      if (!base_mask[0]) begin
        target_onehot = 3'b001;
      end else if (!base_mask[1]) begin
        target_onehot = 3'b010;
      end else if (!base_mask[2]) begin
        target_onehot = 3'b100;
      end
    end

    lane_we   = 3'b000;
    mask_next = mask_reg;
    if (bus.flush) begin
      // Flush wins over both accept and release; lane data is left intact.
      mask_next = 3'b000;
    end else begin
      mask_next = base_mask;
      if (accept_hit) begin
        mask_next = base_mask | target_onehot;
        lane_we   = target_onehot;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Lane data registers
  // -------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_lane
      logic [DATA_WIDTH-1:0] data_reg;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          data_reg <= '0;
        end else if (lane_we[gi]) begin
          data_reg <= bus.din;
        end
      end

      assign lane_data[gi] = data_reg;
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Output logic
  // -------------------------------------------------------------------------
  always_comb begin
    bus.dout_0     = lane_data[0];
    bus.dout_1     = lane_data[1];
    bus.dout_2     = lane_data[2];
    bus.dout_valid = full;
    bus.din_ready  = ready_int;
    bus.fill       = {1'b0, mask_reg[0]} + {1'b0, mask_reg[1]} + {1'b0, mask_reg[2]};
  end

endmodule
